control_unit: RTL

- Multi-cycle fetch/execute controller sitting directly upstream of datapath1; drives its full control word each cycle.
- Consumes the latched instruction (IR) and the ALU status from datapath1.
- Produces register/ALU/memory/PC controls and maintains the architectural flag register FlagReg.
- Implements a LEGv8 subset.

---
 rtl/control_unit.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/control_unit.sv
// Multi-cycle fetch/execute controller for a LEGv8 subset feeding datapath1.
// Outputs are combinational from state and IR; FlagReg latches ALU status on ADDS/SUBS.
module control_unit #(
  parameter logic [4:0] FS_AND   = 5'b00000,
  parameter logic [4:0] FS_OR    = 5'b00100,
  parameter logic [4:0] FS_ADD   = 5'b01000,
  parameter logic [4:0] FS_SUB   = 5'b01001,
  parameter logic [4:0] FS_PASSA = 5'b10000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] IR,
  input  logic [3:0]  status,
  output logic        IL,
  output logic [4:0]  SA,
  output logic [4:0]  SB,
  output logic [4:0]  DA,
  output logic        W,
  output logic [4:0]  FS,
  output logic        C0,
  output logic [63:0] K,
  output logic        B_sel,
  output logic        EN_ALU,
  output logic        EN_B,
  output logic        OUT_EN,
  output logic        WR_EN,
  output logic        EN_ADDR,
  output logic [2:0]  PS,
  output logic [3:0]  FlagReg,
  output logic        halted
);

  typedef enum logic [1:0] {FETCH, EXEC, MEM, HALT} state_t;

  localparam logic [2:0]  PC_HOLD = 3'b000;
  localparam logic [2:0]  PC_INC  = 3'b001;
  localparam logic [2:0]  PC_BR   = 3'b010;

  localparam logic [10:0] OP_ADDS = 11'b10101011000;
  localparam logic [10:0] OP_SUBS = 11'b11101011000;

  state_t      state, state_next;
  logic [10:0] opcode;
  logic [4:0]  rd, rn, rm;
  logic [63:0] imm12_z, doff_s, imm19_s, imm26_s;
  logic        cond_taken;
  logic        flag_load;

  assign opcode  = IR[31:21];
  assign rd      = IR[4:0];
  assign rn      = IR[9:5];
  assign rm      = IR[20:16];
  assign imm12_z = {52'b0, IR[21:10]};
  assign doff_s  = {{55{IR[20]}}, IR[20:12]};
  assign imm19_s = {{45{IR[23]}}, IR[23:5]};
  assign imm26_s = {{38{IR[25]}}, IR[25:0]};

  // B.cond is evaluated on the latched flags {V,C,N,Z}, not the live ALU status.
  always_comb begin
    cond_taken = 1'b0;
    case (IR[3:0])
      4'b0000: cond_taken = FlagReg[0];
      4'b0001: cond_taken = ~FlagReg[0];
      4'b1010: cond_taken = (FlagReg[1] == FlagReg[3]);
      4'b1011: cond_taken = (FlagReg[1] != FlagReg[3]);
      default: cond_taken = 1'b0;
    endcase
  end

  assign flag_load = (state == EXEC) && ((opcode == OP_ADDS) || (opcode == OP_SUBS));

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= FETCH;
      FlagReg <= '0;
    end else begin
      state <= state_next;
      if (flag_load) FlagReg <= status;
    end
  end

  always_comb begin
    state_next = state;
    IL      = 1'b0;
    SA      = '0;
    SB      = '0;
    DA      = '0;
    W       = 1'b0;
    FS      = '0;
    C0      = 1'b0;
    K       = '0;
    B_sel   = 1'b0;
    EN_ALU  = 1'b0;
    EN_B    = 1'b0;
    OUT_EN  = 1'b0;
    WR_EN   = 1'b0;
    EN_ADDR = 1'b0;
    PS      = PC_HOLD;
    halted  = 1'b0;

    unique case (state)
      FETCH: begin
        IL         = 1'b1;
        OUT_EN     = 1'b1;
        state_next = EXEC;
      end
      EXEC: begin
        if (IR == 32'h0) begin
          state_next = HALT;
        end else begin
          state_next = FETCH;
          casez (opcode)
            11'b10001011000, 11'b10101011000: begin
              SA = rn; SB = rm; DA = rd; W = 1'b1; EN_ALU = 1'b1;
              FS = FS_ADD; PS = PC_INC;
            end
            11'b11001011000, 11'b11101011000: begin
              SA = rn; SB = rm; DA = rd; W = 1'b1; EN_ALU = 1'b1;
              FS = FS_SUB; C0 = 1'b1; PS = PC_INC;
            end
            11'b10001010000: begin
              SA = rn; SB = rm; DA = rd; W = 1'b1; EN_ALU = 1'b1;
              FS = FS_AND; PS = PC_INC;
            end
            11'b10101010000: begin
              SA = rn; SB = rm; DA = rd; W = 1'b1; EN_ALU = 1'b1;
              FS = FS_OR; PS = PC_INC;
            end
            11'b1001000100?: begin
              SA = rn; SB = rm; DA = rd; W = 1'b1; EN_ALU = 1'b1;
              FS = FS_ADD; B_sel = 1'b1; K = imm12_z; PS = PC_INC;
            end
            11'b1101000100?: begin
              SA = rn; SB = rm; DA = rd; W = 1'b1; EN_ALU = 1'b1;
              FS = FS_SUB; C0 = 1'b1; B_sel = 1'b1; K = imm12_z; PS = PC_INC;
            end
            11'b11111000010: begin
              SA = rn; B_sel = 1'b1; K = doff_s; FS = FS_ADD;
              EN_ADDR = 1'b1; OUT_EN = 1'b1;
              state_next = MEM;
            end
            11'b11111000000: begin
              SA = rn; SB = rd; B_sel = 1'b1; K = doff_s; FS = FS_ADD;
              EN_ADDR = 1'b1; EN_B = 1'b1; WR_EN = 1'b1; PS = PC_INC;
            end
            11'b1011010????: begin
              // IR[24] is 0 for CBZ (branch on Z=1) and 1 for CBNZ (branch on Z=0).
              SA = rd; FS = FS_PASSA; K = imm19_s;
              PS = (status[0] != IR[24]) ? PC_BR : PC_INC;
            end
            11'b000101?????: begin
              K = imm26_s; PS = PC_BR;
            end
            11'b01010100???: begin
              K = imm19_s; PS = cond_taken ? PC_BR : PC_INC;
            end
            default: PS = PC_INC;
          endcase
        end
      end
      MEM: begin
        // Address operands are held so the ALU keeps presenting the load address.
        SA = rn; B_sel = 1'b1; K = doff_s; FS = FS_ADD;
        EN_ADDR = 1'b1; OUT_EN = 1'b1; W = 1'b1; DA = rd; PS = PC_INC;
        state_next = FETCH;
      end
      HALT: begin
        halted = 1'b1;
      end
    endcase

    if (reset) begin
      W     = 1'b0;
      WR_EN = 1'b0;
      IL    = 1'b0;
      PS    = PC_HOLD;
    end
  end

endmodule
